udlx_trace_buffer: RTL

Synthesisable, parametrised trace-capture unit for the UDLX processor. It records instruction-fetch and data-memory transactions from up to NUM_CH processor bus channels into a circular on-chip buffer, with fill-stop and trigger-centred capture modes. The captured trace is read back one entry per request once capture ends. It sits beside dlx_processor in top, tapping the same signals the simulation monitor watches, so the bus can be traced on the DE2-115 board without a simulator.

---
 rtl/udlx_trace_buffer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/udlx_trace_buffer.sv
// Trace-capture unit: records one bus transaction per cycle from NUM_CH channels into a circular buffer.
// Optional timestamp field enabled by defining UDLX_TRACE_TIMESTAMP_EN.
module udlx_trace_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 20,
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 64,
  parameter int POST_TRIG  = 32,
  parameter int TS_WIDTH   = 16,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W     = $clog2(DEPTH),
`ifdef UDLX_TRACE_TIMESTAMP_EN
  localparam int TS_BITS   = TS_WIDTH,
`else
  // No ts field; TS_WIDTH stays in the parameter list so both builds share one interface.
  localparam int TS_BITS   = 0 * TS_WIDTH,
`endif
  localparam int ENTRY_W   = TS_BITS + CH_W + 1 + ADDR_WIDTH + DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH-1:0]            ch_is_wr,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic                         arm,
  input  logic                         mode,
  input  logic                         trig,
  input  logic                         rd_en,
  output logic                         rd_valid,
  output logic [ENTRY_W-1:0]           rd_entry,
  output logic [1:0]                   state,
  output logic [PTR_W:0]               count,
  output logic                         overflow,
  output logic [15:0]                  drop_cnt
);

  localparam int CNT_W = $clog2(NUM_CH + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_CAPTURE = 2'b01,
    S_POST    = 2'b10,
    S_DONE    = 2'b11
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic                    r_mode;
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr, r_post_cnt;
  logic [PTR_W:0]          r_count;
  logic                    r_overflow;
  logic [15:0]             r_drop_cnt;
  logic                    r_rd_vld_p1;
  logic [ENTRY_W-1:0]      r_rd_entry_p1;
  logic [ENTRY_W-1:0]      r_mem [DEPTH];

  logic                    w_any;
  logic [CH_W-1:0]         w_win;
  logic                    w_win_wr;
  logic [ADDR_WIDTH-1:0]   w_win_addr;
  logic [DATA_WIDTH-1:0]   w_win_data;
  logic [CNT_W-1:0]        w_nvalid;
  logic                    w_cap, w_full, w_rd, w_trig;
  logic [ENTRY_W-1:0]      w_entry;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CNT_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Priority pick: scanning downward leaves the lowest-index valid channel as winner.
  always_comb begin
    w_any      = 1'b0;
    w_win      = '0;
    w_win_wr   = 1'b0;
    w_win_addr = '0;
    w_win_data = '0;
    w_nvalid   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_valid[i]) begin
        w_any      = 1'b1;
        w_win      = CH_W'(i);
        w_win_wr   = ch_is_wr[i];
        w_win_addr = ch_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_win_data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_nvalid   = w_nvalid + CNT_W'(1);
      end
    end
  end

  assign w_cap  = !arm && w_any && (r_state == S_CAPTURE || r_state == S_POST);
  assign w_full = (r_count == (PTR_W+1)'(DEPTH));
  assign w_rd   = !arm && rd_en && (r_state == S_DONE) && (r_count != '0);
  assign w_trig = !arm && trig && r_mode && (r_state == S_CAPTURE);

`ifdef UDLX_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] r_ts;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_ts <= '0;
    else if (arm) r_ts <= '0;
    else          r_ts <= r_ts + TS_WIDTH'(1);
  end

  assign w_entry = {r_ts, w_win, w_win_wr, w_win_addr, w_win_data};
`else
  assign w_entry = {w_win, w_win_wr, w_win_addr, w_win_data};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (arm) begin
      w_state_nxt = S_CAPTURE;
    end else begin
      case (r_state)
        S_CAPTURE: begin
          if (w_cap && !r_mode && r_count == (PTR_W+1)'(DEPTH - 1)) w_state_nxt = S_DONE;
          else if (w_trig)                                          w_state_nxt = S_POST;
        end
        S_POST:    if (w_cap && r_post_cnt == PTR_W'(1)) w_state_nxt = S_DONE;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Capture stage: buffer RAM has no reset so its contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_cap) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode        <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_post_cnt    <= '0;
      r_count       <= '0;
      r_overflow    <= 1'b0;
      r_drop_cnt    <= '0;
      r_rd_vld_p1   <= 1'b0;
      r_rd_entry_p1 <= '0;
    end else if (arm) begin
      r_mode      <= mode;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_post_cnt  <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_drop_cnt  <= '0;
      r_rd_vld_p1 <= 1'b0;
    end else begin
      r_rd_vld_p1 <= w_rd;
      if (w_rd) begin
        r_rd_entry_p1 <= r_mem[r_rd_ptr];
        r_rd_ptr      <= r_rd_ptr + PTR_W'(1);
        r_count       <= r_count - (PTR_W+1)'(1);
      end
      if (w_cap) begin
        r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        r_drop_cnt <= sat_add16(r_drop_cnt, w_nvalid - CNT_W'(1));
        // A full buffer only occurs in trigger mode: overwrite the oldest entry.
        if (w_full) begin
          r_rd_ptr   <= r_rd_ptr + PTR_W'(1);
          r_overflow <= 1'b1;
        end else begin
          r_count    <= r_count + (PTR_W+1)'(1);
        end
        if (r_state == S_POST) r_post_cnt <= r_post_cnt - PTR_W'(1);
      end
      if (w_trig) r_post_cnt <= PTR_W'(POST_TRIG);
    end
  end

  assign rd_valid = r_rd_vld_p1;
  assign rd_entry = r_rd_entry_p1;
  assign state    = r_state;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule
